// File: rtl/drr_pkg.sv
// drr_pkg: shared types, widths and defaults for the deficit round-robin scheduler.
package drr_pkg;
   typedef enum logic [1:0] {IDLE, SELECT, SEND} state_t;
   localparam int LEN_W = 8;
   localparam int DEF_W = 17;
   localparam int QW = 16;
   localparam int NUM_IN_LOG2_DEF = 3;
   localparam int DATA_W_DEF = 64;
   localparam int QUANT_RST_DEF = 16;
   function automatic logic [DEF_W-1:0] sat_add(input logic [DEF_W-1:0] a, input logic [QW-1:0] b);
      logic [DEF_W:0] s;
      s = {1'b0, a} + {{(DEF_W+1-QW){1'b0}}, b};
      return s[DEF_W] ? '1 : s[DEF_W-1:0];
   endfunction
endpackage

// File: rtl/drr_cfg_regs.sv
// drr_cfg_regs: per-queue quantum register bank with a single write port.
module drr_cfg_regs
   import drr_pkg::*;
#(
   parameter int NUM_IN_LOG2 = NUM_IN_LOG2_DEF,
   parameter int QUANT_RST = QUANT_RST_DEF,
   localparam int N = 1 << NUM_IN_LOG2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we_i,
   input  logic [NUM_IN_LOG2-1:0] addr_i,
   input  logic [QW-1:0]          quantum_i,
   output logic [N-1:0][QW-1:0]   quantum_o
);
   logic [N-1:0][QW-1:0] q_q;
   always_ff @(posedge clk) begin
      if (rst) q_q <= {N{QW'(QUANT_RST)}};
      else if (we_i) q_q[addr_i] <= quantum_i;
   end
   assign quantum_o = q_q;
endmodule

// File: rtl/drr_sched.sv
// drr_sched: deficit round-robin scheduler draining N show-ahead FIFOs packet by packet.
module drr_sched
   import drr_pkg::*;
#(
   parameter int NUM_IN_LOG2 = NUM_IN_LOG2_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int QUANT_RST = QUANT_RST_DEF,
   localparam int N = 1 << NUM_IN_LOG2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N-1:0]              fifo_empty,
   input  logic [N-1:0][DATA_W-1:0]  fifo_data,
   output logic [N-1:0]              fifo_rdreq,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_sop,
   output logic                      out_eop,
   input  logic                      cfg_we,
   input  logic [NUM_IN_LOG2-1:0]    cfg_addr,
   input  logic [QW-1:0]             cfg_quantum,
   output logic                      busy
);
   state_t                    state_q, state_d;
   logic [NUM_IN_LOG2-1:0]    ptr_q, ptr_d, cur_q, cur_d;
   logic                      fresh_q, fresh_d, first_q, first_d;
   logic [LEN_W-1:0]          rem_q, rem_d, len;
   logic [N-1:0][DEF_W-1:0]   def_q, def_d;
   logic [N-1:0][QW-1:0]      quantum;
   logic [DEF_W-1:0]          d;

   drr_cfg_regs #(.NUM_IN_LOG2(NUM_IN_LOG2), .QUANT_RST(QUANT_RST)) u_cfg (
      .clk(clk), .rst(rst), .we_i(cfg_we), .addr_i(cfg_addr),
      .quantum_i(cfg_quantum), .quantum_o(quantum)
   );

   // a zero length header still carries one word
   assign len = (fifo_data[ptr_q][LEN_W-1:0] == '0) ? LEN_W'(1) : fifo_data[ptr_q][LEN_W-1:0];
   assign d = sat_add(def_q[ptr_q], fresh_q ? quantum[ptr_q] : '0);

   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      cur_d = cur_q;
      fresh_d = fresh_q;
      first_d = first_q;
      rem_d = rem_q;
      def_d = def_q;
      fifo_rdreq = '0;
      out_valid = 1'b0;
      out_sop = 1'b0;
      out_eop = 1'b0;
      busy = 1'b0;
      out_data = fifo_data[cur_q];
      unique case (state_q)
         IDLE: begin
            fresh_d = 1'b1;
            if (!(&fifo_empty)) state_d = SELECT;
         end
         SELECT: begin
            if (fifo_empty[ptr_q] || quantum[ptr_q] == '0) begin
               def_d[ptr_q] = '0;
               ptr_d = ptr_q + NUM_IN_LOG2'(1);
               fresh_d = 1'b1;
               if (&fifo_empty) state_d = IDLE;
            end else if (DEF_W'(len) <= d) begin
               def_d[ptr_q] = d - DEF_W'(len);
               cur_d = ptr_q;
               rem_d = len;
               first_d = 1'b1;
               fresh_d = 1'b0;
               state_d = SEND;
            end else begin
               def_d[ptr_q] = d;
               ptr_d = ptr_q + NUM_IN_LOG2'(1);
               fresh_d = 1'b1;
            end
         end
         SEND: begin
            busy = 1'b1;
            out_valid = !fifo_empty[cur_q];
            out_sop = out_valid && first_q;
            out_eop = out_valid && rem_q == LEN_W'(1);
            fifo_rdreq[cur_q] = out_valid && out_ready;
            if (out_valid && out_ready) begin
               rem_d = rem_q - LEN_W'(1);
               first_d = 1'b0;
               if (rem_q == LEN_W'(1)) begin
                  state_d = SELECT;
                  fresh_d = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q <= '0;
         cur_q <= '0;
         fresh_q <= 1'b1;
         first_q <= 1'b0;
         rem_q <= '0;
         def_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         cur_q <= cur_d;
         fresh_q <= fresh_d;
         first_q <= first_d;
         rem_q <= rem_d;
         def_q <= def_d;
      end
   end
endmodule

// File: doc/drr_sched.md
DRR_SCHED -- requirements
Module: drr_sched

Interface
REQ-001 SHALL have parameter NUM_IN_LOG2, default 3, log2 of the input queue count N.
REQ-002 SHALL have parameter DATA_W, default 64, data word width.
REQ-003 SHALL have parameter QUANT_RST, default 16, reset quantum in words for every queue.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port fifo_empty  in  [N]  per-queue show-ahead FIFO empty.
REQ-007 SHALL have port fifo_data  in  [N][DATA_W]  per-queue FIFO head word; bits[7:0] of a header word = packet length in words, header included.
REQ-008 SHALL have port fifo_rdreq  out  [N]  per-queue pop, one word per asserted cycle.
REQ-009 SHALL have port out_valid  out  1  output beat valid.
REQ-010 SHALL have port out_ready  in  1  downstream accept.
REQ-011 SHALL have port out_data  out  DATA_W  output beat.
REQ-012 SHALL have ports out_sop / out_eop  out  1 each  first / last beat of a packet.
REQ-013 SHALL have ports cfg_we  in  1, cfg_addr  in  NUM_IN_LOG2, cfg_quantum  in  16  quantum write.
REQ-014 SHALL have port busy  out  1  high in SEND.

Function
REQ-015 SHALL implement FSM IDLE, SELECT, SEND; the round-robin pointer ptr resets to 0.
REQ-016 IDLE: SHALL go to SELECT the cycle after any fifo_empty is low; ptr unchanged; fresh flag set.
REQ-017 SELECT: SHALL examine exactly one queue (ptr) per cycle; if all queues are empty, go to IDLE.
REQ-018 SELECT, queue empty or quantum 0: SHALL set deficit[ptr] to 0, advance ptr mod N, and set fresh.
REQ-019 SELECT, queue non-empty: SHALL compute d = deficit + (fresh ? quantum : 0), saturating at 17 bits (0x1FFFF), and clear fresh.
REQ-020 If len <= d, SHALL store deficit = d - len, latch cur = ptr and remaining = len, and enter SEND; length 0 SHALL be treated as 1.
REQ-021 If len > d, SHALL store deficit = d, advance ptr, and set fresh.
REQ-022 SEND: out_data SHALL equal fifo_data[cur] combinationally; out_valid SHALL equal !fifo_empty[cur].
REQ-023 SEND: fifo_rdreq[cur] SHALL equal out_valid && out_ready; all other rdreq bits SHALL be 0 in every state.
REQ-024 A beat SHALL transfer only when out_valid && out_ready; each transfer decrements remaining.
REQ-025 out_sop SHALL be high on the first beat of a packet; out_eop SHALL be high when remaining == 1.
REQ-026 A FIFO underflow mid-packet SHALL stall SEND with out_valid low; there is no timeout.
REQ-027 On the eop transfer, SHALL return to SELECT on the same ptr with fresh clear.
REQ-028 Outside SEND, out_valid, out_sop, out_eop and busy SHALL be 0; out_data is don't-care.
REQ-029 A cfg_we write SHALL update quantum[cfg_addr] at the clock edge; the new value applies at that queue's next fresh visit; a write during SEND SHALL not disturb the packet in flight.

Reset
REQ-030 rst SHALL force IDLE, ptr 0, fresh 1, all deficits 0, remaining 0, and quanta to QUANT_RST; all outputs SHALL be 0 in the following cycle, including on a reset mid-packet. No FIFO flush is required.

Structure
REQ-031 Package drr_pkg SHALL hold the state enum, LEN_W=8, DEF_W=17, QW=16 and default parameters.
REQ-032 Sub-module drr_cfg_regs SHALL hold the quantum register bank and the cfg write port; the deficit bank and FSM SHALL stay in drr_sched.

Verification
REQ-033 Reset with all FIFOs full: out_valid 0, rdreq 0, busy 0 during rst and 1 cycle after.
REQ-034 Q0 quantum 16, one packet of len 4: 4 beats, sop on beat 1, eop on beat 4, rdreq[0] high for 4 cycles, deficit[0] = 12 afterwards, then deficit[0] = 0 once Q0 is found empty.
REQ-035 Q0 quantum 8 and Q1 quantum 16, both backlogged with len-8 packets: over 6 rounds, Q1 sends 12 packets and Q0 sends 6.
REQ-036 out_ready low for 3 cycles mid-packet: out_data held stable, rdreq 0 for those cycles, no beat lost or duplicated.
REQ-037 Q3 quantum 16, len-40 packet: Q3 skipped on visits 1-2, served on visit 3, deficit[3] = 8 after.
REQ-038 Q2 quantum 0, backlogged: never served, deficit[2] 0; rst asserted at beat 2 of a Q5 packet: out_valid 0 the next cycle, all deficits 0.
